// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequencer for the shared multi-cycle MULTU/DIVU datapath
//
// Decodes the execute-stage function field and owns the op code seen by the
// ALU, shifter, divider and result mux. MULTU/DIVU occupy the shared path for
// CYCLES iteration cycles followed by a single HiLo write cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   funct        6-bit function field of the instruction in execute
//   funct_valid  funct holds a real instruction this cycle
//   op_out       registered op code; 6'b111111 marks the HiLo write cycle
//   mul_start    one-cycle pulse: multiplier clears and loads operands
//   div_start    one-cycle pulse: divider clears and loads operands
//   hilo_we      one-cycle HiLo write enable
//   busy         sequencer is not idle
//   stall        valid instruction must wait because the shared path is busy
module muldiv_sequencer #(
    parameter int CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] funct,
    input  logic       funct_valid,
    output logic [5:0] op_out,
    output logic       mul_start,
    output logic       div_start,
    output logic       hilo_we,
    output logic       busy,
    output logic       stall
);

    localparam logic [5:0] F_MULTU  = 6'd25;
    localparam logic [5:0] F_DIVU   = 6'd27;
    localparam logic [5:0] OP_HILO  = 6'b111111;
    localparam logic [6:0] CNT_LAST = 7'(CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [6:0] cnt, cnt_nx;
    logic [5:0] op_nx;
    logic       mul_nx, div_nx, we_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 7'd0;
            op_out    <= 6'd0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            hilo_we   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            op_out    <= op_nx;
            mul_start <= mul_nx;
            div_start <= div_nx;
            hilo_we   <= we_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_out;
        mul_nx   = 1'b0;
        div_nx   = 1'b0;
        we_nx    = 1'b0;
        case (state)
            IDLE: begin
                // Every code, known or not, passes straight through to the
                // shared units; only MULTU/DIVU take ownership of the path.
                op_nx = funct_valid ? funct : 6'd0;
                if (funct_valid && (funct == F_MULTU)) begin
                    state_nx = RUN;
                    cnt_nx   = 7'd0;
                    mul_nx   = 1'b1;
                end else if (funct_valid && (funct == F_DIVU)) begin
                    state_nx = RUN;
                    cnt_nx   = 7'd0;
                    div_nx   = 1'b1;
                end
            end
            RUN: begin
                // op_out keeps the accepted code; funct is ignored here.
                cnt_nx = cnt + 7'd1;
                if (cnt == CNT_LAST) begin
                    state_nx = WRITE;
                    op_nx    = OP_HILO;
                    we_nx    = 1'b1;
                    cnt_nx   = 7'd0;
                end
            end
            WRITE: begin
                // funct is deliberately not sampled on this edge, so a stalled
                // instruction is accepted one cycle later from IDLE.
                state_nx = IDLE;
                op_nx    = 6'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 7'd0;
                op_nx    = 6'd0;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    // ALU ops stall too because op_out owns every shared unit, and MFHI/MFLO
    // must not read HiLo before the pending write lands.
    assign stall = funct_valid & busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] funct = 6'd0;
    logic       funct_valid = 1'b0;

    logic [5:0] op_w [2];
    logic       mul_w [2];
    logic       div_w [2];
    logic       we_w [2];
    logic       busy_w [2];
    logic       stall_w [2];

    always #5 clk = ~clk;

    muldiv_sequencer #(.CYCLES(32)) u_c32 (
        .clk(clk), .rst_n(rst_n), .funct(funct), .funct_valid(funct_valid),
        .op_out(op_w[0]), .mul_start(mul_w[0]), .div_start(div_w[0]),
        .hilo_we(we_w[0]), .busy(busy_w[0]), .stall(stall_w[0])
    );

    muldiv_sequencer #(.CYCLES(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .funct(funct), .funct_valid(funct_valid),
        .op_out(op_w[1]), .mul_start(mul_w[1]), .div_start(div_w[1]),
        .hilo_we(we_w[1]), .busy(busy_w[1]), .stall(stall_w[1])
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: rem = busy cycles still ahead including the current one.
    int         cyc [2] = '{32, 2};
    int         rem [2];
    logic [5:0] job [2];
    logic [5:0] iop [2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            job[i] = 6'd0;
            iop[i] = 6'd0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rem[i] == 0) begin
                iop[i] = funct_valid ? funct : 6'd0;
                if (funct_valid && (funct == 6'd25 || funct == 6'd27)) begin
                    rem[i] = cyc[i] + 1;
                    job[i] = funct;
                end
            end else begin
                rem[i] = rem[i] - 1;
                iop[i] = 6'd0;
            end
        end
    endtask

    task automatic compare_all();
        int eop;
        for (int i = 0; i < 2; i++) begin
            eop = (rem[i] > 1) ? int'(job[i]) : (rem[i] == 1) ? 63 : int'(iop[i]);
            chk($sformatf("op_out[%0d]", i), int'(op_w[i]), eop);
            chk($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(rem[i] > 0));
            chk($sformatf("hilo_we[%0d]", i), int'(we_w[i]), int'(rem[i] == 1));
            chk($sformatf("mul_start[%0d]", i), int'(mul_w[i]),
                int'(rem[i] == cyc[i] + 1 && job[i] == 6'd25));
            chk($sformatf("div_start[%0d]", i), int'(div_w[i]),
                int'(rem[i] == cyc[i] + 1 && job[i] == 6'd27));
            chk($sformatf("stall[%0d]", i), int'(stall_w[i]),
                int'(funct_valid && rem[i] > 0));
        end
    endtask

    // One clock: model follows the edge, DUT is compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " op_out"}, int'(op_w[0]), 0);
        chk({nm, " busy"}, int'(busy_w[0]), 0);
        chk({nm, " mul_start"}, int'(mul_w[0]), 0);
        chk({nm, " div_start"}, int'(div_w[0]), 0);
        chk({nm, " hilo_we"}, int'(we_w[0]), 0);
    endtask

    logic [5:0] alu_seq [5] = '{6'd36, 6'd37, 6'd34, 6'd42, 6'd2};

    initial begin
        int n_busy, n_op, n_mul, n_div, n_we, we_idx0, we_idx1, n_stall, guard;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Release with ADD valid.
        funct = 6'd32;
        funct_valid = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("add op_out", int'(op_w[0]), 32);
        chk("add busy", int'(busy_w[0]), 0);

        // Single-cycle ALU ops back to back.
        foreach (alu_seq[k]) begin
            funct = alu_seq[k];
            tick();
            chk($sformatf("alu op_out %0d", k), int'(op_w[0]), int'(alu_seq[k]));
            chk($sformatf("alu stall %0d", k), int'(stall_w[0]), 0);
        end
        funct_valid = 1'b0;
        tick();
        chk("idle op_out", int'(op_w[0]), 0);

        // MULTU on both instances (CYCLES 32 and 2).
        funct = 6'd25;
        funct_valid = 1'b1;
        tick();
        funct_valid = 1'b0;
        funct = 6'd0;
        n_busy = 0; n_op = 0; n_mul = 0; n_we = 0; n_div = 0;
        we_idx0 = -1; we_idx1 = -1;
        for (int k = 0; k < 40; k++) begin
            n_busy += int'(busy_w[0]);
            n_op   += int'(op_w[0] == 6'd25);
            n_mul  += int'(mul_w[0]);
            n_div  += int'(div_w[0]);
            n_we   += int'(we_w[0]);
            if (we_w[0]) we_idx0 = k;
            if (we_w[1]) we_idx1 = k;
            if (k == 0) chk("mul_start first cycle", int'(mul_w[0]), 1);
            tick();
        end
        chk("multu busy cycles", n_busy, 33);
        chk("multu op25 cycles", n_op, 32);
        chk("multu mul pulses", n_mul, 1);
        chk("multu div pulses", n_div, 0);
        chk("multu hilo writes", n_we, 1);
        chk("multu hilo cycle c32", we_idx0, 32);
        chk("multu hilo cycle c2", we_idx1, 2);

        // DIVU followed by MFHI held valid.
        funct = 6'd27;
        funct_valid = 1'b1;
        tick();
        funct = 6'd16;
        n_stall = 0; n_div = 0; n_mul = 0; guard = 0;
        while (busy_w[0] && guard < 100) begin
            n_stall += int'(stall_w[0]);
            n_div   += int'(div_w[0]);
            n_mul   += int'(mul_w[0]);
            guard++;
            tick();
        end
        chk("divu busy bound", int'(guard < 100), 1);
        chk("divu stall cycles", n_stall, 33);
        chk("divu div pulses", n_div, 1);
        chk("divu mul pulses", n_mul, 0);
        tick();
        chk("mfhi op_out", int'(op_w[0]), 16);
        chk("mfhi busy", int'(busy_w[0]), 0);
        funct_valid = 1'b0;
        funct = 6'd0;
        tick();

        // Async reset at RUN cycle 10.
        funct = 6'd25;
        funct_valid = 1'b1;
        tick();
        funct_valid = 1'b0;
        funct = 6'd0;
        repeat (9) tick();
        chk("pre-reset busy", int'(busy_w[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid-run reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n_we = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_we += int'(we_w[0]);
        end
        chk("no hilo after reset", n_we, 0);

        // MULTU after the reset completes normally.
        funct = 6'd25;
        funct_valid = 1'b1;
        tick();
        funct_valid = 1'b0;
        funct = 6'd0;
        n_busy = 0; n_we = 0;
        for (int k = 0; k < 40; k++) begin
            n_busy += int'(busy_w[0]);
            n_we   += int'(we_w[0]);
            tick();
        end
        chk("post-reset busy cycles", n_busy, 33);
        chk("post-reset hilo writes", n_we, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the shared multi-cycle MULTU/DIVU path in the execution stage. Decodes the 6-bit function field, drives the operation code to the ALU, shifter, divider and result mux, runs multiply/divide for a fixed number of cycles, then issues a single HiLo write. Stalls the issuing stage while the shared datapath is occupied. It replaces free-running function-code forwarding with an explicit, resettable state machine.

## Interface
- CYCLES, 32, iteration cycles per MULTU/DIVU; legal range 2..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- funct  input  6  function field of the instruction in execute
- funct_valid  input  1  funct holds a real instruction this cycle
- op_out  output  6  registered op code to ALU/SHT/DIV/MUX; 6'b111111 = HiLo write
- mul_start  output  1  one-cycle registered pulse: multiplier clears and loads operands
- div_start  output  1  one-cycle registered pulse: divider clears and loads operands
- hilo_we  output  1  one-cycle registered HiLo write enable
- busy  output  1  state != IDLE
- stall  output  1  combinational: funct_valid & busy

## Operation
- Codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18, NOP 0.
- States: IDLE, RUN, WRITE. 7-bit counter cnt.
- IDLE, each edge: op_out <= funct_valid ? funct : 0.
  - funct_valid & funct==MULTU: -> RUN, cnt <= 0, mul_start <= 1.
  - funct_valid & funct==DIVU: -> RUN, cnt <= 0, div_start <= 1.
  - Other codes, including unknown ones, pass through; the state stays IDLE.
- RUN: op_out holds the accepted code. funct is ignored. Start pulses clear after one cycle. cnt increments each edge. At the edge where cnt == CYCLES-1: -> WRITE, op_out <= 6'b111111, hilo_we <= 1, cnt <= 0.
- WRITE: lasts one cycle. At the next edge: -> IDLE, hilo_we <= 0, op_out <= 0. funct is not sampled at this edge; a stalled instruction is accepted one cycle later.
- stall is asserted for every valid instruction while busy. This covers ALU ops too, because op_out owns all shared units, and MFHI/MFLO, which must not read HiLo before it is written.
- Reset (async, any state, including mid-RUN): state IDLE, cnt 0, op_out 0, mul_start 0, div_start 0, hilo_we 0. A reset mid-RUN produces no HiLo write.

## Timing
- Accept edge E0: MULTU/DIVU sampled in IDLE.
- Cycle after E0: RUN; start pulse high; busy high.
- RUN covers cycles E0+1 .. E0+CYCLES.
- WRITE cycle follows E0+CYCLES: op_out = 63 and hilo_we = 1.
- busy is high for CYCLES+1 cycles. The next instruction is accepted at E0+CYCLES+2.
- Single-cycle ops: op_out valid one cycle after the edge that samples funct. busy and stall stay low.
- Back-to-back MULTU then DIVU: the DIVU is stalled through RUN and WRITE. It is accepted at the first IDLE edge, and div_start fires the cycle after.
- funct_valid low in IDLE: op_out = 0 and no state change.

## Test plan
- Reset: hold rst_n low mid-clock -> all outputs 0 immediately, without waiting for a clock edge; release with funct = ADD valid -> op_out = 32 after the first edge, and busy stays 0.
- MULTU, CYCLES = 32 -> mul_start high exactly 1 cycle after the accept edge; op_out = 25 for 32 cycles; then op_out = 63 and hilo_we = 1 for 1 cycle; then busy = 0. Total busy = 33 cycles.
- DIVU immediately followed by MFHI held valid -> stall = 1 for the 33 busy cycles; MFHI is accepted one cycle after busy falls; op_out = 16; div_start pulses once and mul_start never pulses.
- Async reset asserted at RUN cycle 10 -> busy = 0 and op_out = 0 immediately; hilo_we never asserts; a subsequent MULTU completes normally.
- Sequence AND, OR, SUB, SLT, SRL on consecutive cycles with funct_valid = 1 -> op_out = 36, 37, 34, 42, 2, each one cycle later; stall never asserts.
- CYCLES = 2 -> RUN lasts 2 cycles and hilo_we fires on the 3rd cycle after accept.
